mnist_argmax: RTL and testbench
===============================

// Module: mnist_argmax
// PURPOSE
//   Classification stage directly downstream of the MNIST depthwise-separable conv stack.
//   Consumes the final 1x1xNUM_CLASS logit vector (one din_vld beat per frame).
//   Scans the classes serially, one per cycle, and emits the winning class index and its score.
//   Keeps a frame counter and a sticky drop flag for frames that arrive while a scan is running.
// PARAMETERS
//   N          8   logit width, signed two's complement
//   NUM_CLASS  10  number of logits per frame; must be >= 2
//   CNT_W      16  width of frame_cnt
//   IDX_W      derived localparam = $clog2(NUM_CLASS), 4 at default
// PORTS
//   clk          in   1              single clock, rising edge
//   rst          in   1              synchronous reset, active-high
//   din_vld      in   1              logit vector valid (single-beat frame)
//   din          in   NUM_CLASS*N    class c at din[c*N +: N]
//   din_end      in   1              end-of-frame marker from conv stack; must coincide with din_vld
//   busy         out  1              scan in progress; a din_vld now is dropped
//   class_vld    out  1              one-cycle pulse: class_idx/class_score valid
//   class_idx    out  IDX_W          index of max logit
//   class_score  out  N              max logit value (signed)
//   frame_cnt    out  CNT_W          count of class_vld pulses, wraps 2^CNT_W-1 -> 0
//   drop_err     out  1              sticky: a frame was dropped, or din_vld came without din_end
// BEHAVIOUR
//   Reset (rst=1 at an edge)
//     - All outputs go to 0. FSM goes to IDLE and the internal vector register clears.
//     - Reset during SCAN aborts the scan; no class_vld is produced for that frame.
//   FSM states: IDLE, SCAN
//     - IDLE & din_vld at edge E0:
//         capture din into vec_q; best_q <= din[0 +: N]; idx_q <= 0; cnt <= 1; go to SCAN.
//     - SCAN, each edge:
//         if $signed(vec_q[cnt]) > $signed(best_q), then best_q <= that logit and idx_q <= cnt;
//         cnt <= cnt+1.
//     - SCAN with cnt==NUM_CLASS-1:
//         perform the final compare;
//         class_idx/class_score <= final winner; class_vld <= 1; frame_cnt += 1; go to IDLE.
//   Latency
//     - class_vld is high in the cycle after edge E(NUM_CLASS-1), for exactly one cycle.
//       At the default this is 9 edges after capture.
//     - Throughput: one frame per NUM_CLASS cycles.
//   Ties
//     - Strict '>' comparison, so the lowest index wins.
//     - All logits equal -> idx 0.
//   Output holding
//     - class_idx and class_score hold their value until the next class_vld.
//     - They are not cleared when class_vld drops.
//   busy
//     - busy = (state==SCAN); combinational from the state register.
//   Simultaneous events
//     - din_vld while busy: frame ignored, drop_err <= 1, scan continues undisturbed.
//     - din_vld in the class_vld cycle (FSM already in IDLE): accepted normally, no drop.
//     - din_vld without din_end: frame still processed, drop_err <= 1.
//   drop_err clears only on rst.
//   Arithmetic
//     - All compares are signed N-bit.
//     - No saturation or extension is needed; score is passed through unchanged.
// STRUCTURE
//   Shared package mnist_pkg:
//     - localparam N, NUM_CLASS
//     - function clog2
//     - typedef logit_t (signed [N-1:0])
//   Sub-module: mnist_max_cmp.
//     - Combinational signed compare; returns the winner value and index.
//     - Shared with the future top-k block.
//   Everything else (FSM, counters, vector register) is flat in this module.
// TESTING
//   T1 Basic
//     - din = {0,0,0,0,0,0,0,0x7F,0,0} (class 2 = 127), din_vld & din_end one cycle.
//     - Expect class_vld 9 edges later; idx=2, score=0x7F, frame_cnt=1.
//   T2 Negative logits and ties
//     - All logits 0x80 except class 5 = 0xFF (-1).
//       Expect idx=5, score=0xFF.
//     - All logits 0x10.
//       Expect idx=0.
//   T3 Drop
//     - Second din_vld 3 cycles after the first.
//     - Expect the first result only, drop_err=1 held, frame_cnt=1, busy high for 9 cycles.
//   T4 Back-to-back
//     - din_vld in the same cycle as class_vld.
//     - Expect accepted with no drop; second class_vld 10 cycles after the first.
//   T5 Reset mid-scan
//     - Assert rst at scan cycle 4.
//     - Expect no class_vld, all outputs 0, and the next frame to work normally.
//   T6 Wrap
//     - Preload-free run of 2^CNT_W frames (CNT_W=4 override).
//     - Expect frame_cnt 15 -> 0.
//   T7 Missing end-of-frame
//     - din_vld without din_end.
//     - Expect the result produced and drop_err=1.

Source files
------------

// File: rtl/mnist_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mnist_pkg
//  Description : Shared constants, types and helpers for the MNIST classifier
//                back end (argmax stage and the future top-k block).
//  Contents    : N, NUM_CLASS defaults, clog2 helper, logit_t, FSM encodings
//  Revision    : 1.0  initial release
// ============================================================================
package mnist_pkg;

    localparam int N         = 8;
    localparam int NUM_CLASS = 10;

    // Index width for a class count; never returns less than 1 so that a
    // two-class build still gets a usable index bus.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic signed [N-1:0] logit_t;

    // Argmax scan FSM encoding
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_scan = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mnist_max_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_max_cmp
//  Description : Combinational signed max of two (value, index) pairs. The
//                candidate wins only when strictly greater, so on a tie the
//                running (lower-index) entry is kept.
//  Ports       : cur_val/cur_idx   running best
//                cand_val/cand_idx challenger
//                win_val/win_idx   selected pair
//  Revision    : 1.0  initial release
// ============================================================================
module mnist_max_cmp #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic signed [N-1:0]     cur_val,
    input  logic        [IDX_W-1:0] cur_idx,
    input  logic signed [N-1:0]     cand_val,
    input  logic        [IDX_W-1:0] cand_idx,
    output logic signed [N-1:0]     win_val,
    output logic        [IDX_W-1:0] win_idx
);
    import mnist_pkg::*;

    logic w_take;

    assign w_take  = (cand_val > cur_val);
    assign win_val = w_take ? cand_val : cur_val;
    assign win_idx = w_take ? cand_idx : cur_idx;

endmodule
`default_nettype wire

// File: rtl/mnist_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_argmax
//  Description : Serial argmax over a single-beat NUM_CLASS logit vector.
//                One class is compared per cycle; the winner index and score
//                are published with a one-cycle class_vld pulse.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                din_vld/din     logit vector beat (class c at din[c*N +: N])
//                din_end         end-of-frame marker, expected with din_vld
//                busy            scan running; a din_vld now is dropped
//                class_vld       result strobe
//                class_idx       winning class (held until next class_vld)
//                class_score     winning logit  (held until next class_vld)
//                frame_cnt       number of results produced (wrapping)
//                drop_err        sticky frame-dropped / missing-end flag
//  Revision    : 1.0  initial release
// ============================================================================
module mnist_argmax #(
    parameter  int N         = mnist_pkg::N,
    parameter  int NUM_CLASS = mnist_pkg::NUM_CLASS,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = mnist_pkg::clog2(NUM_CLASS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_vld,
    input  logic [NUM_CLASS*N-1:0] din,
    input  logic                   din_end,
    output logic                   busy,
    output logic                   class_vld,
    output logic [IDX_W-1:0]       class_idx,
    output logic [N-1:0]           class_score,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   drop_err
);
    import mnist_pkg::*;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CLASS - 1);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [NUM_CLASS*N-1:0] r_vec;
    logic signed [N-1:0]    r_best;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_cnt;
    logic                   r_class_vld;
    logic [IDX_W-1:0]       r_class_idx;
    logic [N-1:0]           r_class_score;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_drop_err;

    logic signed [N-1:0]    w_logits [NUM_CLASS];
    logic signed [N-1:0]    w_cand;
    logic signed [N-1:0]    w_win_val;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_last;

    // Split the captured vector into per-class logits for the serial select.
    for (genvar g = 0; g < NUM_CLASS; g++) begin : g_unpack
        assign w_logits[g] = r_vec[g*N +: N];
    end

    assign w_cand = w_logits[r_cnt];
    assign w_last = (r_state == c_st_scan) && (r_cnt == c_last_idx);

    mnist_max_cmp #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_max_cmp (
        .cur_val  (r_best),
        .cur_idx  (r_idx),
        .cand_val (w_cand),
        .cand_idx (r_cnt),
        .win_val  (w_win_val),
        .win_idx  (w_win_idx)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (din_vld) w_state_nxt = c_st_scan;
            c_st_scan: if (w_last)  w_state_nxt = c_st_idle;
            default:                w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, result registers, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec         <= '0;
            r_best        <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_class_vld   <= 1'b0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_frame_cnt   <= '0;
            r_drop_err    <= 1'b0;
        end else begin
            r_class_vld <= 1'b0;
            if (r_state == c_st_idle) begin
                if (din_vld) begin
                    // Class 0 seeds the running best; the scan starts at 1.
                    r_vec  <= din;
                    r_best <= din[N-1:0];
                    r_idx  <= '0;
                    r_cnt  <= IDX_W'(1);
                    if (!din_end) begin
                        r_drop_err <= 1'b1;
                    end
                end
            end else begin
                r_best <= w_win_val;
                r_idx  <= w_win_idx;
                r_cnt  <= r_cnt + 1'b1;
                // A frame offered mid-scan is discarded; the scan carries on.
                if (din_vld) begin
                    r_drop_err <= 1'b1;
                end
                if (w_last) begin
                    r_cnt         <= '0;
                    r_class_vld   <= 1'b1;
                    r_class_idx   <= w_win_idx;
                    r_class_score <= w_win_val;
                    r_frame_cnt   <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign busy        = (r_state == c_st_scan);
    assign class_vld   = r_class_vld;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign frame_cnt   = r_frame_cnt;
    assign drop_err    = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_mnist_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mnist_argmax
//  Description : Self-checking bench for mnist_argmax. Table-driven frames
//                plus hand-written sequences for drop, back-to-back, reset
//                mid-scan, missing end-of-frame and frame counter wrap.
//                Expected results are queued at drive time and popped when
//                class_vld is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mnist_argmax;

    localparam int N         = 8;
    localparam int NUM_CLASS = 10;
    localparam int CNT_W     = 4;
    localparam int IW        = 4;
    localparam int NB        = NUM_CLASS * N;

    typedef struct {
        logic [NB-1:0] din;
        logic [IW-1:0] idx;
        logic [N-1:0]  score;
    } vec_t;

    typedef struct {
        logic [IW-1:0]    idx;
        logic [N-1:0]     score;
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             din_vld;
    logic [NB-1:0]    din;
    logic             din_end;
    logic             busy;
    logic             class_vld;
    logic [IW-1:0]    class_idx;
    logic [N-1:0]     class_score;
    logic [CNT_W-1:0] frame_cnt;
    logic             drop_err;

    int               cyc;
    int               n_checks;
    int               n_errors;
    logic [CNT_W-1:0] model_cnt;
    exp_t             sb [$];
    vec_t             tbl [8];

    mnist_argmax #(
        .N         (N),
        .NUM_CLASS (NUM_CLASS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_vld     (din_vld),
        .din         (din),
        .din_end     (din_end),
        .busy        (busy),
        .class_vld   (class_vld),
        .class_idx   (class_idx),
        .class_score (class_score),
        .frame_cnt   (frame_cnt),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Vector with every class = fillv, optionally class pos overridden to v.
    function automatic logic [NB-1:0] mk(input logic [7:0] fillv, input int pos, input logic [7:0] v);
        logic [NB-1:0] r;
        for (int c = 0; c < NUM_CLASS; c++) begin
            r[c*N +: N] = (c == pos) ? v : fillv;
        end
        return r;
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; drives one beat and returns at the next negedge.
    task automatic drive(input logic [NB-1:0] v, input logic e, input bit push,
                         input logic [IW-1:0] ei, input logic [N-1:0] es);
        exp_t x;
        din     = v;
        din_vld = 1'b1;
        din_end = e;
        if (push) begin
            model_cnt = model_cnt + 1'b1;
            x.idx   = ei;
            x.score = es;
            x.cnt   = model_cnt;
            x.cyc   = cyc + NUM_CLASS;
            sb.push_back(x);
        end
        @(negedge clk);
        din_vld = 1'b0;
        din_end = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"},   32'(class_vld),   32'd0);
        check({tag, "_idx"},   32'(class_idx),   32'd0);
        check({tag, "_score"}, 32'(class_score), 32'd0);
        check({tag, "_cnt"},   32'(frame_cnt),   32'd0);
        check({tag, "_drop"},  32'(drop_err),    32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (class_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_class_vld", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("class_idx",   32'(class_idx),   32'(e.idx));
                check("class_score", 32'(class_score), 32'(e.score));
                check("frame_cnt",   32'(frame_cnt),   32'(e.cnt));
                check("latency",     32'(cyc),         32'(e.cyc));
            end
        end
    end

    initial begin
        int t0;
        logic [NB-1:0] v;
        n_checks  = 0;
        n_errors  = 0;
        model_cnt = '0;
        rst       = 1'b1;
        din_vld   = 1'b0;
        din_end   = 1'b0;
        din       = '0;

        v = mk(8'hC0, 3, 8'h40);
        v[7*N +: N] = 8'h40;
        tbl[0] = '{mk(8'h00, 2, 8'h7F),  4'd2, 8'h7F};
        tbl[1] = '{mk(8'h80, 5, 8'hFF),  4'd5, 8'hFF};
        tbl[2] = '{mk(8'h10, -1, 8'h00), 4'd0, 8'h10};
        tbl[3] = '{mk(8'h01, 9, 8'h05),  4'd9, 8'h05};
        tbl[4] = '{mk(8'hFF, 0, 8'h00),  4'd0, 8'h00};
        tbl[5] = '{v,                    4'd3, 8'h40};
        tbl[6] = '{mk(8'h80, -1, 8'h00), 4'd0, 8'h80};
        tbl[7] = '{mk(8'h7E, 6, 8'h7F),  4'd6, 8'h7F};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // T1/T2 and friends: isolated frames from the table
        foreach (tbl[i]) begin
            drive(tbl[i].din, 1'b1, 1'b1, tbl[i].idx, tbl[i].score);
            repeat (11) @(negedge clk);
            check("busy_idle_after_frame", 32'(busy), 32'd0);
        end
        check("no_drop_clean_frames", 32'(drop_err), 32'd0);

        // Outputs hold after the strobe drops
        check("hold_idx",   32'(class_idx),   32'd6);
        check("hold_score", 32'(class_score), 32'h7F);

        // T4: second frame presented in the class_vld cycle of the first
        t0 = cyc;
        drive(mk(8'h00, 8, 8'h22), 1'b1, 1'b1, 4'd8, 8'h22);
        wait_to(t0 + NUM_CLASS);
        drive(mk(8'hF0, 1, 8'hF1), 1'b1, 1'b1, 4'd1, 8'hF1);
        repeat (11) @(negedge clk);
        check("no_drop_back_to_back", 32'(drop_err), 32'd0);

        // T3: second frame 3 cycles into the scan is dropped
        t0 = cyc;
        drive(mk(8'h00, 4, 8'h33), 1'b1, 1'b1, 4'd4, 8'h33);
        for (int i = 1; i <= NUM_CLASS; i++) begin
            wait_to(t0 + i);
            check("busy_window", 32'(busy), (i <= NUM_CLASS - 1) ? 32'd1 : 32'd0);
            if (i == 3) begin
                din     = mk(8'h00, 7, 8'h7F);
                din_vld = 1'b1;
                din_end = 1'b1;
            end else begin
                din_vld = 1'b0;
                din_end = 1'b0;
            end
        end
        repeat (12) @(negedge clk);
        check("drop_err_set", 32'(drop_err), 32'd1);
        check("drop_frame_cnt", 32'(frame_cnt), 32'(model_cnt));

        // T5: reset mid-scan aborts the frame
        t0 = cyc;
        drive(mk(8'h00, 1, 8'h55), 1'b1, 1'b0, 4'd0, 8'h00);
        wait_to(t0 + 4);
        rst       = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midscan_reset");
        repeat (12) @(negedge clk);
        check("midscan_no_result", 32'(frame_cnt), 32'd0);
        drive(mk(8'h80, 9, 8'h81), 1'b1, 1'b1, 4'd9, 8'h81);
        repeat (11) @(negedge clk);
        check("after_reset_no_drop", 32'(drop_err), 32'd0);

        // T7: missing end-of-frame still produces a result
        drive(mk(8'h05, 3, 8'h06), 1'b0, 1'b1, 4'd3, 8'h06);
        repeat (11) @(negedge clk);
        check("missing_end_drop", 32'(drop_err), 32'd1);

        // T6: 2^CNT_W frames from reset, counter wraps to 0
        rst       = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < (1 << CNT_W); f++) begin
            drive(mk(8'h00, f % NUM_CLASS, 8'h11), 1'b1, 1'b1,
                  IW'(f % NUM_CLASS), 8'h11);
            repeat (10) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        // Drain: every queued result must have appeared
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
